// File: rtl/apb_spi_master_fifo.sv
// rtl/apb_spi_master_fifo.sv - APB slave to SPI master bridge with TX/RX FIFOs,
// runtime CPOL/CPHA, burst transfers with SS held, sticky flags and interrupt.
module apb_spi_master_fifo #(
  parameter int DATA_W     = 8,
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_PCLK,
  input  logic              i_PRESETn,
  input  logic              i_PSEL,
  input  logic              i_PENABLE,
  input  logic              i_PWRITE,
  input  logic [15:0]       i_PADDR,
  input  logic [DATA_W-1:0] i_PWDATA,
  input  logic [9:0]        i_BASE_ADDR,
  output logic [DATA_W-1:0] o_PRDATA,
  output logic              o_PREADY,
  output logic              o_PSLVERR,
  output logic              o_SCK,
  output logic              o_MOSI,
  input  logic              i_MISO,
  output logic [NUM_SS-1:0] o_SS_N,
  output logic              o_IRQ
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = $clog2(2 * DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_TRAIL = 2'd3;

  logic [1:0]        state;
  logic [1:0]        cfg_div, cfg_ss;
  logic              cfg_cpha, cfg_cpol, cfg_ie;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic              rx_ovf, tx_ovf, done;
  logic [3:0]        div_cnt;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-1:0] tx_sh, rx_sh;

  logic       access, busy, tx_full, tx_empty, rx_full, rx_empty;
  logic [3:0] off;
  logic       ss_bad, cfg_ok, tx_wr, tx_push, tx_pop, rx_rd, rx_pop, st_rd;
  logic       cmd_wr, flush, start, half_done, trail_end, rx_push;
  logic [7:0] status;

  assign access    = i_PSEL & i_PENABLE & (i_PADDR[15:6] == i_BASE_ADDR);
  assign off       = i_PADDR[5:2];
  assign busy      = (state != S_IDLE);
  assign tx_full   = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty  = (tx_cnt == '0);
  assign rx_full   = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty  = (rx_cnt == '0);
  assign ss_bad    = (int'(i_PWDATA[3:2]) >= NUM_SS);
  assign cfg_ok    = access & i_PWRITE & (off == 4'd0) & ~busy & ~ss_bad;
  assign tx_wr     = access & i_PWRITE & (off == 4'd1);
  assign tx_push   = tx_wr & ~tx_full;
  assign rx_rd     = access & ~i_PWRITE & (off == 4'd1);
  assign rx_pop    = rx_rd & ~rx_empty;
  assign st_rd     = access & ~i_PWRITE & (off == 4'd0);
  assign cmd_wr    = access & i_PWRITE & (off == 4'd3) & ~busy;
  assign flush     = cmd_wr & i_PWDATA[0];
  // FLUSH wins over START in the same write: the TX word would be gone anyway
  assign start     = cmd_wr & ~i_PWDATA[0] & i_PWDATA[1] & ~tx_empty;
  assign half_done = (div_cnt == ((4'd1 << cfg_div) - 4'd1));
  assign trail_end = (state == S_TRAIL) & half_done;
  assign tx_pop    = start | (trail_end & ~tx_empty);
  assign rx_push   = trail_end & ~rx_full;
  assign status    = {done, tx_ovf, rx_ovf, rx_empty, rx_full, tx_empty, tx_full, busy};
  assign o_PREADY  = 1'b1;

  always_comb begin
    o_PSLVERR = 1'b0;
    if (access) begin
      case (off)
        4'd0:    o_PSLVERR = i_PWRITE & (busy | ss_bad);
        4'd1:    o_PSLVERR = 1'b0;
        4'd3:    o_PSLVERR = i_PWRITE & busy & i_PWDATA[0];
        default: o_PSLVERR = 1'b1;
      endcase
    end
  end

  always_comb begin
    o_PRDATA = '0;
    if (st_rd) o_PRDATA[7:0] = status;
    else if (rx_pop) o_PRDATA = rx_mem[rx_rp];
  end

  always_ff @(posedge i_PCLK) begin
    if (tx_push) tx_mem[tx_wp] <= i_PWDATA;
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky flags: a set in the same cycle as a STATUS read survives the clear
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      cfg_div <= '0; cfg_ss <= '0; cfg_cpha <= 1'b0; cfg_cpol <= 1'b0; cfg_ie <= 1'b0;
      rx_ovf <= 1'b0; tx_ovf <= 1'b0; done <= 1'b0; o_IRQ <= 1'b0;
    end else begin
      if (cfg_ok) begin
        cfg_div  <= i_PWDATA[1:0];
        cfg_ss   <= i_PWDATA[3:2];
        cfg_cpha <= i_PWDATA[4];
        cfg_cpol <= i_PWDATA[5];
        cfg_ie   <= i_PWDATA[6];
      end
      if (st_rd) begin
        rx_ovf <= 1'b0; tx_ovf <= 1'b0; done <= 1'b0;
      end
      if (tx_wr & tx_full)     tx_ovf <= 1'b1;
      if (trail_end & rx_full) rx_ovf <= 1'b1;
      if (trail_end & tx_empty) done  <= 1'b1;
      o_IRQ <= cfg_ie & (done | rx_ovf | tx_ovf);
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state <= S_IDLE; div_cnt <= '0; edge_cnt <= '0;
      tx_sh <= '0; rx_sh <= '0;
      o_SCK <= 1'b0; o_MOSI <= 1'b0; o_SS_N <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          o_SCK   <= cfg_cpol;
          o_SS_N  <= '1;
          div_cnt <= '0;
          if (start) begin
            state  <= S_LEAD;
            tx_sh  <= tx_mem[tx_rp];
            o_MOSI <= tx_mem[tx_rp][DATA_W-1];
            o_SS_N <= ~(NUM_SS'(1) << cfg_ss);
          end
        end
        S_LEAD: begin
          if (half_done) begin
            state    <= S_SHIFT;
            div_cnt  <= '0;
            edge_cnt <= '0;
            o_SCK    <= ~cfg_cpol;
            if (!cfg_cpha) rx_sh <= {rx_sh[DATA_W-2:0], i_MISO};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            if (edge_cnt == EW'(2 * DATA_W - 1)) begin
              state <= S_TRAIL;
            end else begin
              edge_cnt <= edge_cnt + 1'b1;
              o_SCK    <= ~o_SCK;
              // Odd edge_cnt means the coming edge is leading
              if (edge_cnt[0] == cfg_cpha) begin
                tx_sh  <= tx_sh << 1;
                o_MOSI <= tx_sh[DATA_W-2];
              end else begin
                rx_sh <= {rx_sh[DATA_W-2:0], i_MISO};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          if (half_done) begin
            div_cnt <= '0;
            if (!tx_empty) begin
              state  <= S_LEAD;
              tx_sh  <= tx_mem[tx_rp];
              o_MOSI <= tx_mem[tx_rp][DATA_W-1];
            end else begin
              state  <= S_IDLE;
              o_SS_N <= '1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_spi_master_fifo.sv
// tb/tb_apb_spi_master_fifo.sv - randomized scoreboard bench for apb_spi_master_fifo
module tb_apb_spi_master_fifo;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int D  = 4;
  localparam logic [9:0] BASE  = 10'h12A;
  localparam logic [9:0] BASE2 = 10'h055;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          rd;
  } apb_exp_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ss;
    logic          cpol;
    logic          cpha;
    logic [1:0]    div;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [9:0] base_a = BASE, base_b = BASE2;
  logic [DW-1:0] prdata, prdata2;
  logic pready, pready2, pslverr, pslverr2, sck, sck2, mosi, mosi2, irq, irq2;
  logic [NS-1:0] ss_n;
  logic [1:0] ss_n2;

  always #5 clk = ~clk;

  apb_spi_master_fifo #(.DATA_W(DW), .NUM_SS(NS), .FIFO_DEPTH(D)) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata), .i_BASE_ADDR(base_a),
    .o_PRDATA(prdata), .o_PREADY(pready), .o_PSLVERR(pslverr), .o_SCK(sck),
    .o_MOSI(mosi), .i_MISO(mosi), .o_SS_N(ss_n), .o_IRQ(irq)
  );

  apb_spi_master_fifo #(.DATA_W(DW), .NUM_SS(2), .FIFO_DEPTH(D)) dut2 (
    .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata), .i_BASE_ADDR(base_b),
    .o_PRDATA(prdata2), .o_PREADY(pready2), .o_PSLVERR(pslverr2), .o_SCK(sck2),
    .o_MOSI(mosi2), .i_MISO(1'b0), .o_SS_N(ss_n2), .o_IRQ(irq2)
  );

  int errors = 0;
  int checks = 0;
  apb_exp_t apb_q[$];
  frame_t   frame_q[$];

  logic [DW-1:0] m_tx[$];
  logic [DW-1:0] m_rx[$];
  logic m_rx_ovf = 1'b0, m_tx_ovf = 1'b0, m_done = 1'b0;
  logic m_ie = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
  logic [1:0] m_div = '0, m_ss = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin : mon_apb
    apb_exp_t e;
    if (rst_n && psel && penable && paddr[15:6] == BASE) begin
      check("pready", pready, 1'b1);
      if (apb_q.size() == 0) begin
        check("apb_unexpected", 1'b1, 1'b0);
      end else begin
        e = apb_q.pop_front();
        check("pslverr", pslverr, e.err);
        if (e.rd) check("prdata", prdata, e.data);
      end
    end
  end

  logic prev_sck = 1'b0;
  int bitcnt = 0, ecnt = 0, cyc = 0;
  bit hp_bad = 1'b0;
  logic [DW-1:0] sh = '0;

  always @(negedge clk) begin : mon_spi
    frame_t f;
    logic leading;
    logic [NS-1:0] exp_ss;
    if (!rst_n) begin
      bitcnt = 0; ecnt = 0; cyc = 0; hp_bad = 1'b0; prev_sck = sck;
    end else begin
      cyc++;
      if (ss_n != {NS{1'b1}} && sck != prev_sck) begin
        if (frame_q.size() == 0) begin
          check("unexpected_sck", 1'b1, 1'b0);
        end else begin
          f = frame_q[0];
          if (ecnt > 0 && cyc != (1 << f.div)) hp_bad = 1'b1;
          leading = (prev_sck == f.cpol);
          if (leading == !f.cpha) begin
            sh = {sh[DW-2:0], mosi};
            bitcnt++;
          end
          ecnt++;
          cyc = 0;
          if (ecnt == 2 * DW) begin
            exp_ss = ~(NS'(1) << f.ss);
            check("mosi_frame", sh, f.data);
            check("ss_n_frame", ss_n, exp_ss);
            check("frame_bits", bitcnt, DW);
            check("half_period", hp_bad, 1'b0);
            void'(frame_q.pop_front());
            bitcnt = 0; ecnt = 0; hp_bad = 1'b0;
          end
        end
      end
      prev_sck = sck;
    end
  end

  task automatic apb(input logic wr, input logic [9:0] base, input logic [3:0] off,
                     input logic [DW-1:0] wd, output logic [DW-1:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {base, off, 2'b00}; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rd  = (base == BASE) ? prdata : prdata2;
    err = (base == BASE) ? pslverr : pslverr2;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic exp_apb(input logic [DW-1:0] data, input logic err, input logic rd);
    apb_q.push_back('{data: data, err: err, rd: rd});
  endtask

  task automatic wr_cfg(input logic [DW-1:0] v, input logic busy);
    logic [DW-1:0] rd; logic err;
    exp_apb('0, busy, 1'b0);
    if (!busy) begin
      m_div = v[1:0]; m_ss = v[3:2]; m_cpha = v[4]; m_cpol = v[5]; m_ie = v[6];
    end
    apb(1'b1, BASE, 4'd0, v, rd, err);
  endtask

  task automatic push_tx(input logic [DW-1:0] v);
    logic [DW-1:0] rd; logic err;
    exp_apb('0, 1'b0, 1'b0);
    if (m_tx.size() < D) m_tx.push_back(v);
    else m_tx_ovf = 1'b1;
    apb(1'b1, BASE, 4'd1, v, rd, err);
  endtask

  task automatic flush_cmd(input logic busy);
    logic [DW-1:0] rd; logic err;
    exp_apb('0, busy, 1'b0);
    if (!busy) begin
      m_tx.delete(); m_rx.delete();
    end
    apb(1'b1, BASE, 4'd3, 8'h01, rd, err);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ss_n !== {NS{1'b1}} && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", n < 8000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("sck_idle", sck, m_cpol);
    check("frames_pending", frame_q.size(), 0);
  endtask

  task automatic start_cmd(input bit wait_done);
    logic [DW-1:0] rd, v; logic err; bit go;
    go = (m_tx.size() > 0);
    exp_apb('0, 1'b0, 1'b0);
    while (m_tx.size() > 0) begin
      v = m_tx.pop_front();
      frame_q.push_back('{data: v, ss: m_ss, cpol: m_cpol, cpha: m_cpha, div: m_div});
      if (m_rx.size() < D) m_rx.push_back(v);
      else m_rx_ovf = 1'b1;
    end
    if (go) m_done = 1'b1;
    apb(1'b1, BASE, 4'd3, 8'h02, rd, err);
    if (go && wait_done) wait_idle();
  endtask

  task automatic read_rx();
    logic [DW-1:0] rd, e; logic err;
    e = (m_rx.size() > 0) ? m_rx.pop_front() : '0;
    exp_apb(e, 1'b0, 1'b1);
    apb(1'b0, BASE, 4'd1, '0, rd, err);
  endtask

  task automatic read_status();
    logic [DW-1:0] rd, e; logic err;
    e = '0;
    e[7:0] = {m_done, m_tx_ovf, m_rx_ovf, m_rx.size() == 0, m_rx.size() == D,
              m_tx.size() == 0, m_tx.size() == D, 1'b0};
    exp_apb(e, 1'b0, 1'b1);
    m_done = 1'b0; m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
    apb(1'b0, BASE, 4'd0, '0, rd, err);
  endtask

  task automatic check_irq();
    repeat (2) @(posedge clk);
    #1;
    check("irq", irq, m_ie & (m_done | m_rx_ovf | m_tx_ovf));
  endtask

  initial begin : stim
    logic [DW-1:0] rd; logic err; int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", ss_n, {NS{1'b1}});
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_prdata", prdata, '0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_pready", pready, 1'b1);
    rst_n = 1'b1;
    read_status();

    wr_cfg(8'h00, 1'b0);
    push_tx(8'h55);
    start_cmd(1'b1);
    read_rx();
    read_status();
    read_status();

    wr_cfg(8'h3D, 1'b0);
    push_tx(8'hA5); push_tx(8'h3C); push_tx(8'h0F);
    start_cmd(1'b1);
    repeat (3) read_rx();
    read_status();

    wr_cfg(8'h40, 1'b0);
    for (int i = 0; i <= D; i++) push_tx(DW'($urandom));
    check_irq();
    read_status();
    check_irq();
    start_cmd(1'b1);
    check_irq();
    repeat (D) read_rx();
    read_status();

    wr_cfg(8'h41, 1'b0);
    for (int i = 0; i < D; i++) push_tx(DW'($urandom));
    start_cmd(1'b1);
    push_tx(DW'($urandom));
    start_cmd(1'b1);
    read_status();
    repeat (D) read_rx();
    read_rx();

    wr_cfg(8'h03, 1'b0);
    push_tx(8'h96); push_tx(8'h18); push_tx(8'hE7);
    start_cmd(1'b0);
    wr_cfg(8'h00, 1'b1);
    flush_cmd(1'b1);
    wait_idle();
    repeat (3) read_rx();
    read_status();

    push_tx(8'h11); push_tx(8'h22);
    flush_cmd(1'b0);
    read_status();
    exp_apb('0, 1'b1, 1'b0);
    apb(1'b0, BASE, 4'd2, '0, rd, err);
    exp_apb('0, 1'b1, 1'b0);
    apb(1'b1, BASE, 4'd5, 8'hFF, rd, err);
    read_rx();

    apb(1'b1, BASE2, 4'd0, 8'h0C, rd, err);
    check("ss_range_err", err, 1'b1);
    apb(1'b1, BASE2, 4'd0, 8'h04, rd, err);
    check("ss_range_ok", err, 1'b0);

    for (int it = 0; it < 6; it++) begin
      wr_cfg(DW'($urandom_range(0, 127)), 1'b0);
      n = $urandom_range(1, D + 1);
      for (int i = 0; i < n; i++) push_tx(DW'($urandom));
      start_cmd(1'b1);
      check_irq();
      n = $urandom_range(0, D);
      for (int i = 0; i < n; i++) read_rx();
      read_status();
    end

    wr_cfg(8'h23, 1'b0);
    push_tx(8'hC3); push_tx(8'h5A);
    start_cmd(1'b0);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ss_n", ss_n, {NS{1'b1}});
    check("midrst_sck", sck, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    m_tx.delete(); m_rx.delete(); frame_q.delete(); apb_q.delete();
    m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_done = 1'b0;
    m_ie = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; m_div = '0; m_ss = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_status();
    check_irq();

    repeat (4) @(posedge clk);
    #1;
    check("apb_q_drained", apb_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
